// File: rtl/hazard_mc_if.sv
// Hazard-unit bundle: D/E/M/W register fields and controls toward the hazard
// unit, stall/flush/forward selects back to the datapath.
interface hazard_mc_if #(
    parameter int REGW = 5
);
    logic [REGW-1:0] rsD, rtD;
    logic            branchD, jrD;
    logic [REGW-1:0] rsE, rtE, writeregE;
    logic            regwriteE, memtoregE, mdstartE;
    logic [REGW-1:0] writeregM;
    logic            regwriteM, memtoregM, excM;
    logic [REGW-1:0] writeregW;
    logic            regwriteW;
    logic            forwardaD, forwardbD;
    logic [1:0]      forwardaE, forwardbE;
    logic            stallF, stallD, stallE;
    logic            flushD, flushE, flushM;
    logic            md_busy, md_done;

    modport master (
        output rsD, rtD, branchD, jrD,
        output rsE, rtE, writeregE, regwriteE, memtoregE, mdstartE,
        output writeregM, regwriteM, memtoregM, excM,
        output writeregW, regwriteW,
        input  forwardaD, forwardbD, forwardaE, forwardbE,
        input  stallF, stallD, stallE, flushD, flushE, flushM,
        input  md_busy, md_done
    );

    modport slave (
        input  rsD, rtD, branchD, jrD,
        input  rsE, rtE, writeregE, regwriteE, memtoregE, mdstartE,
        input  writeregM, regwriteM, memtoregM, excM,
        input  writeregW, regwriteW,
        output forwardaD, forwardbD, forwardaE, forwardbE,
        output stallF, stallD, stallE, flushD, flushE, flushM,
        output md_busy, md_done
    );
endinterface

// File: rtl/hazard_mc.sv
// Hazard/forwarding unit for the 5-stage MIPS pipeline with a MUL/DIV busy FSM
// and M-stage exception flush. Define HAZARD_STATS_EN to add statistics counters.
module hazard_mc #(
    parameter int REGW       = 5,
    parameter int MD_LATENCY = 32,
    parameter int CNTW       = 8,
    parameter int STATW      = 32
) (
    input  logic             clk,
    input  logic             rst,
`ifdef HAZARD_STATS_EN
    output logic [STATW-1:0] stall_cycles,
    output logic [STATW-1:0] md_cycles,
    output logic [STATW-1:0] flush_events,
`endif
    hazard_mc_if.slave       hz
);

    if ((2 ** CNTW) <= MD_LATENCY || MD_LATENCY < 2 || MD_LATENCY > 255 || STATW < 1) begin : gBadParams
        $error("hazard_mc: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mdState_e;

    mdState_e        state, stateNext;
    logic [CNTW-1:0] cnt, cntNext;
    logic            lwStall, brStall, mdStall;

    // A dependency exists only on a live producer and a non-$0 source.
    function automatic logic depHit(input logic [REGW-1:0] src,
                                    input logic [REGW-1:0] dst,
                                    input logic            en);
        return en && (src != '0) && (src == dst);
    endfunction

    function automatic logic [1:0] fwdSelE(input logic [REGW-1:0] src,
                                           input logic [REGW-1:0] wrM,
                                           input logic            rwM,
                                           input logic [REGW-1:0] wrW,
                                           input logic            rwW);
        if (depHit(src, wrM, rwM)) return 2'b10;
        if (depHit(src, wrW, rwW)) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        lwStall = depHit(hz.rsD, hz.writeregE, hz.memtoregE) ||
                  depHit(hz.rtD, hz.writeregE, hz.memtoregE);
        // JR only reads rs; a conditional branch compares both sources.
        brStall = (hz.branchD || hz.jrD) &&
                  (depHit(hz.rsD, hz.writeregE, hz.regwriteE) ||
                   depHit(hz.rsD, hz.writeregM, hz.memtoregM) ||
                   (hz.branchD && (depHit(hz.rtD, hz.writeregE, hz.regwriteE) ||
                                   depHit(hz.rtD, hz.writeregM, hz.memtoregM))));
        mdStall = ((state == IDLE) && hz.mdstartE) || (state == BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE: if (hz.mdstartE) begin
                stateNext = BUSY;
                cntNext   = CNTW'(MD_LATENCY - 1);
            end
            BUSY: if (cnt == '0) stateNext = DONE;
                  else           cntNext   = cnt - 1'b1;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        // An exception aborts any MUL/DIV in flight and blocks a new start.
        if (hz.excM) begin
            stateNext = IDLE;
            cntNext   = '0;
        end
    end

    always_comb begin
        hz.forwardaD = 1'b0;
        hz.forwardbD = 1'b0;
        hz.forwardaE = 2'b00;
        hz.forwardbE = 2'b00;
        hz.stallF    = 1'b0;
        hz.stallD    = 1'b0;
        hz.stallE    = 1'b0;
        hz.flushD    = 1'b0;
        hz.flushE    = 1'b0;
        hz.flushM    = 1'b0;
        hz.md_busy   = 1'b0;
        hz.md_done   = 1'b0;
        if (rst) begin
            hz.flushD = 1'b1;
            hz.flushE = 1'b1;
            hz.flushM = 1'b1;
        end else begin
            hz.forwardaD = depHit(hz.rsD, hz.writeregM, hz.regwriteM);
            hz.forwardbD = depHit(hz.rtD, hz.writeregM, hz.regwriteM);
            hz.forwardaE = fwdSelE(hz.rsE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
            hz.forwardbE = fwdSelE(hz.rtE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
            hz.md_busy   = (state == BUSY);
            hz.md_done   = (state == DONE);
            if (hz.excM) begin
                hz.flushD = 1'b1;
                hz.flushE = 1'b1;
                hz.flushM = 1'b1;
            end else begin
                hz.stallF = mdStall || lwStall || brStall;
                hz.stallD = mdStall || lwStall || brStall;
                hz.stallE = mdStall;
                hz.flushE = !mdStall && (lwStall || brStall);
                hz.flushM = mdStall;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    function automatic logic [STATW-1:0] satInc(input logic [STATW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            md_cycles    <= '0;
            flush_events <= '0;
        end else begin
            if (hz.stallF)  stall_cycles <= satInc(stall_cycles);
            if (hz.md_busy) md_cycles    <= satInc(md_cycles);
            if (hz.excM)    flush_events <= satInc(flush_events);
        end
    end
`endif

endmodule
